mc_controller: RTL and testbench

Multicycle control FSM for the RV32I core. It sequences a shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback, with a ready/valid-style memory handshake. Instruction decode fields come from the datapath's instruction register. ALU function selection is delegated to the existing ALU decoder through `ALUOp`.

---
 rtl/rv32_pkg.sv | 45 ++++
 rtl/branch_logic.sv | 22 ++
 rtl/mc_controller.sv | 153 +++++++++++++++
 tb/tb_mc_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I multicycle core: FSM states, opcodes
// and datapath mux encodings.
package rv32_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR, S_EXECI,
    S_LUI, S_AUIPC, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC, S_TRAP
  } mc_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [2:0] MEMSIZE_WORD = 3'b010;

endpackage

// File: rtl/branch_logic.sv
// Branch condition from funct3 and the ALU compare flags of rs1 - rs2.
module branch_logic (
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       NEG,
  input  logic       NEGU,
  output logic       taken
);

  always_comb begin
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = NEG;
      3'b101:  taken = ~NEG;
      3'b110:  taken = NEGU;
      3'b111:  taken = ~NEGU;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the RV32I core: fetch/decode/execute/memory/
// writeback sequencing with a ready/valid memory handshake.
module mc_controller
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       NEG,
  input  logic       NEGU,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic [2:0] MemSize,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic       illegal_instr,
  output logic       instr_retired
);

  mc_state_t state, next;
  logic      ill_q;
  logic      taken;

  branch_logic u_branch (
    .funct3(funct3), .Zero(Zero), .NEG(NEG), .NEGU(NEGU), .taken(taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ill_q <= 1'b0;
    end else begin
      state <= next;
      if (state == S_DECODE && next == S_TRAP) ill_q <= 1'b1;
    end
  end

  always_comb begin
    next = state;
    case (state)
      S_FETCH:   if (mem_ready) next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_OP:             next = S_EXECR;
          OP_IMM:            next = S_EXECI;
          OP_LUI:            next = S_LUI;
          OP_AUIPC:          next = S_AUIPC;
          OP_BRANCH:         next = S_BRANCH;
          OP_JAL:            next = S_JAL;
          OP_JALR:           next = S_JALR;
          default:           next = S_TRAP;
        endcase
      end
      S_MEMADR:  next = opcode[5] ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) next = S_MEMWB;
      S_MEMWR:   if (mem_ready) next = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH: next = S_FETCH;
      S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL, S_JALR_PC: next = S_ALUWB;
      S_JALR:    next = S_JALR_PC;
      default:   next = S_TRAP;
    endcase
  end

  // The reset state is FETCH, so outputs are gated to keep mem_req low while rst_n is held.
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ALUOp         = ALUOP_ADD;
    ResultSrc     = RES_ALUOUT;
    MemSize       = MEMSIZE_WORD;
    instr_retired = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALU;
          end
        end
        S_DECODE: begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
        S_MEMADR: begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_IMM; end
        S_MEMRD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
          MemSize = funct3;
        end
        S_MEMWB: begin
          ResultSrc     = RES_DATA;
          RegWrite      = 1'b1;
          instr_retired = 1'b1;
        end
        S_MEMWR: begin
          mem_req       = 1'b1;
          mem_we        = 1'b1;
          AdrSrc        = 1'b1;
          MemSize       = funct3;
          instr_retired = mem_ready;
        end
        S_EXECR: begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUOp = ALUOP_FUNCT; end
        S_EXECI: begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_FUNCT; end
        S_LUI:   begin ALUSrcA = SRCA_ZERO;  ALUSrcB = SRCB_IMM; end
        S_AUIPC: begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
        S_ALUWB: begin RegWrite = 1'b1; instr_retired = 1'b1; end
        S_BRANCH: begin
          ALUSrcA       = SRCA_RS1;
          ALUOp         = ALUOP_SUB;
          PCWrite       = taken;
          instr_retired = 1'b1;
        end
        S_JAL, S_JALR_PC: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_FOUR;
          PCWrite = 1'b1;
        end
        S_JALR:  begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (opcode)
      OP_STORE:        ImmSrc = IMM_S;
      OP_BRANCH:       ImmSrc = IMM_B;
      OP_LUI, OP_AUIPC: ImmSrc = IMM_U;
      OP_JAL:          ImmSrc = IMM_J;
      default:         ImmSrc = IMM_I;
    endcase
  end

  assign illegal_instr = ill_q;

endmodule

// File: tb/tb_mc_controller.sv
// Cycle-accurate scoreboard bench for mc_controller: expected output vectors
// are queued as each cycle's stimulus is driven and compared mid-cycle.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       Zero = 1'b0, NEG = 1'b0, NEGU = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [2:0] MemSize, ImmSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic       illegal_instr, instr_retired;

  mc_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .Zero(Zero), .NEG(NEG), .NEGU(NEGU), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .MemSize(MemSize), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .illegal_instr(illegal_instr), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  typedef enum {T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
                T_EXECR, T_EXECI, T_LUI, T_AUIPC, T_ALUWB, T_BRANCH, T_JAL,
                T_JALR, T_JALR_PC, T_TRAP} tst_t;

  typedef struct { string tag; logic [21:0] v; } sb_t;
  sb_t sb[$];
  sb_t ent;
  int  checks = 0, errors = 0, seq = 0;

  logic [21:0] obs;
  assign obs = {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, ResultSrc, instr_retired, illegal_instr, MemSize, ImmSrc};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [2:0] imm_exp(input logic [6:0] op);
    case (op)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b0110111, 7'b0010111: return 3'b011;
      7'b1101111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle, straight from the per-state output table.
  function automatic logic [21:0] exp_out(input tst_t st, input bit rdy, input bit tk);
    logic req = 0, we = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ret = 0, ill = 0;
    logic [1:0] sa = 0, sb_ = 0, op = 0, rs = 0;
    logic [2:0] ms = 3'b010;
    case (st)
      T_FETCH:   begin req = 1; if (rdy) begin irw = 1; pcw = 1; sb_ = 2; rs = 2; end end
      T_DECODE:  begin sa = 1; sb_ = 1; end
      T_MEMADR:  begin sa = 2; sb_ = 1; end
      T_MEMRD:   begin req = 1; adr = 1; ms = funct3; end
      T_MEMWB:   begin rs = 1; rw = 1; ret = 1; end
      T_MEMWR:   begin req = 1; we = 1; adr = 1; ms = funct3; ret = rdy; end
      T_EXECR:   begin sa = 2; sb_ = 0; op = 2; end
      T_EXECI:   begin sa = 2; sb_ = 1; op = 2; end
      T_LUI:     begin sa = 3; sb_ = 1; end
      T_AUIPC:   begin sa = 1; sb_ = 1; end
      T_ALUWB:   begin rw = 1; ret = 1; end
      T_BRANCH:  begin sa = 2; op = 1; pcw = tk; ret = 1; end
      T_JAL, T_JALR_PC: begin sa = 1; sb_ = 2; pcw = 1; end
      T_JALR:    begin sa = 2; sb_ = 1; end
      T_TRAP:    ill = 1;
      default:   ;
    endcase
    return {req, we, adr, irw, pcw, rw, sa, sb_, op, rs, ret, ill, ms, imm_exp(opcode)};
  endfunction

  task automatic push(input tst_t st, input bit rdy, input bit tk);
    sb_t e;
    mem_ready = rdy;
    e.tag = $sformatf("%s#%0d", st.name(), seq);
    e.v = exp_out(st, rdy, tk);
    seq++;
    sb.push_back(e);
  endtask

  task automatic step(input tst_t st, input bit rdy, input bit tk);
    @(negedge clk);
    push(st, rdy, tk);
  endtask

  // Starts a new instruction (also releases reset if held) with a number of fetch wait cycles.
  task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input int waits);
    @(negedge clk);
    opcode = op;
    funct3 = f3;
    rst_n = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      if (i > 0) @(negedge clk);
      push(T_FETCH, i == waits, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (sb.size() != 0) begin
      ent = sb.pop_front();
      chk(ent.tag, {10'd0, obs}, {10'd0, ent.v});
    end
  end

  initial begin
    // reset held
    step(T_RST, 1, 0);
    step(T_RST, 1, 0);
    // add, zero wait
    fetch(7'b0110011, 3'b000, 0);
    step(T_DECODE, 1, 0); step(T_EXECR, 1, 0); step(T_ALUWB, 1, 0);
    // addi
    fetch(7'b0010011, 3'b000, 0);
    step(T_DECODE, 1, 0); step(T_EXECI, 1, 0); step(T_ALUWB, 1, 0);
    // lbu with 2 fetch waits and 3 data waits
    fetch(7'b0000011, 3'b100, 2);
    step(T_DECODE, 1, 0); step(T_MEMADR, 1, 0);
    for (int i = 0; i < 3; i++) step(T_MEMRD, 0, 0);
    step(T_MEMRD, 1, 0); step(T_MEMWB, 1, 0);
    // sh, zero wait
    fetch(7'b0100011, 3'b001, 0);
    step(T_DECODE, 1, 0); step(T_MEMADR, 1, 0); step(T_MEMWR, 1, 0);
    // lui / auipc
    fetch(7'b0110111, 3'b000, 0);
    step(T_DECODE, 1, 0); step(T_LUI, 1, 0); step(T_ALUWB, 1, 0);
    fetch(7'b0010111, 3'b000, 0);
    step(T_DECODE, 1, 0); step(T_AUIPC, 1, 0); step(T_ALUWB, 1, 0);
    // beq taken
    fetch(7'b1100011, 3'b000, 0);
    Zero = 1; NEG = 0; NEGU = 1;
    step(T_DECODE, 1, 0); step(T_BRANCH, 1, 1);
    // bltu not taken
    fetch(7'b1100011, 3'b110, 0);
    Zero = 1; NEG = 1; NEGU = 0;
    step(T_DECODE, 1, 0); step(T_BRANCH, 1, 0);
    // bge not taken, bne taken
    fetch(7'b1100011, 3'b101, 0);
    Zero = 0; NEG = 1; NEGU = 0;
    step(T_DECODE, 1, 0); step(T_BRANCH, 1, 0);
    fetch(7'b1100011, 3'b001, 0);
    step(T_DECODE, 1, 0); step(T_BRANCH, 1, 1);
    Zero = 0; NEG = 0; NEGU = 0;
    // jal, jalr
    fetch(7'b1101111, 3'b000, 0);
    step(T_DECODE, 1, 0); step(T_JAL, 1, 0); step(T_ALUWB, 1, 0);
    fetch(7'b1100111, 3'b000, 0);
    step(T_DECODE, 1, 0); step(T_JALR, 1, 0); step(T_JALR_PC, 1, 0); step(T_ALUWB, 1, 0);
    // sw with a wait, reset dropped mid-wait
    fetch(7'b0100011, 3'b010, 0);
    step(T_DECODE, 1, 0); step(T_MEMADR, 1, 0); step(T_MEMWR, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_access", {10'd0, obs}, {10'd0, exp_out(T_RST, 0, 0)});
    step(T_RST, 0, 0);
    fetch(7'b0110011, 3'b000, 0);
    step(T_DECODE, 1, 0); step(T_EXECR, 1, 0); step(T_ALUWB, 1, 0);
    // illegal opcode, absorbing trap, then reset recovery
    fetch(7'h0B, 3'b000, 0);
    step(T_DECODE, 1, 0);
    for (int i = 0; i < 3; i++) step(T_TRAP, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    push(T_RST, 0, 0);
    step(T_RST, 0, 0);
    fetch(7'b0110011, 3'b000, 0);
    step(T_DECODE, 1, 0); step(T_EXECR, 1, 0); step(T_ALUWB, 1, 0);
    @(negedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
